// File: rtl/wdt_ctrl.sv
// Watchdog timer control: sequences an external register-bank down-counter through
// enable, interrupt and reset-pulse phases. Optional macro WDT_PRESCALE_EN adds a count prescaler.
module wdt_ctrl #(
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter int unsigned PRESCALE_DIV     = 8
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        inten,
    input  logic        resen,
    input  logic        stall,
    input  logic        dbg_halt,
    input  logic        test_en,
    input  logic        int_clr,
    input  logic [31:0] wdtvalue,
    output logic        count_en,
    output logic        load_en,
    output logic        interrupt,
    output logic        cause_rst,
    output logic        wdogres
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] INT_PEND = 2'd2;
    localparam logic [1:0] RST_OUT  = 2'd3;

    localparam int unsigned   PW         = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);

    if (RST_PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("wdt_ctrl: RST_PULSE_CYCLES must be >= 1");
    end
    if (PRESCALE_DIV < 2) begin : g_bad_div
        $error("wdt_ctrl: PRESCALE_DIV must be >= 2");
    end

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] pulse_cnt;
    logic          tick;
    logic          zero_evt;
    logic          pulse_done;
    logic          load_raw;
    logic          int_nxt;
    logic          cause_nxt;

    // Gating with presetn keeps the strobes quiet while reset is held.
    assign tick = presetn && ((state == RUN) || (state == INT_PEND)) && !(stall && dbg_halt);

`ifdef WDT_PRESCALE_EN
    localparam int unsigned   DW       = $clog2(PRESCALE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(PRESCALE_DIV - 1);

    logic [DW-1:0] pre_cnt;

    assign count_en = tick && (pre_cnt == DIV_LAST);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            pre_cnt <= '0;
        end else if (load_en) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= (pre_cnt == DIV_LAST) ? '0 : pre_cnt + 1'b1;
        end
    end
`else
    assign count_en = tick;
`endif

    assign zero_evt   = count_en && (wdtvalue == 32'd0);
    assign pulse_done = (pulse_cnt == PULSE_LAST);
    assign load_en    = presetn && load_raw;

    always_comb begin
        state_nxt = state;
        load_raw  = 1'b0;
        int_nxt   = interrupt;
        cause_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (inten) begin
                    state_nxt = RUN;
                    load_raw  = 1'b1;
                end
            end
            RUN, INT_PEND: begin
                // Disable beats clear, and clear beats a coincident zero event.
                if (!inten) begin
                    state_nxt = IDLE;
                    int_nxt   = 1'b0;
                end else if (int_clr) begin
                    state_nxt = RUN;
                    load_raw  = 1'b1;
                    int_nxt   = 1'b0;
                end else if (zero_evt) begin
                    if ((state == INT_PEND) && resen) begin
                        state_nxt = RST_OUT;
                        cause_nxt = 1'b1;
                    end else begin
                        state_nxt = INT_PEND;
                        load_raw  = 1'b1;
                        int_nxt   = 1'b1;
                    end
                end
            end
            RST_OUT: begin
                if (pulse_done) begin
                    int_nxt = 1'b0;
                    if (inten) begin
                        state_nxt = RUN;
                        load_raw  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            cause_rst <= 1'b0;
            wdogres   <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            state     <= state_nxt;
            interrupt <= int_nxt;
            cause_rst <= cause_nxt;
            wdogres   <= (state_nxt == RST_OUT) && !test_en;
            if (state == RST_OUT) begin
                pulse_cnt <= pulse_done ? '0 : pulse_cnt + 1'b1;
            end else begin
                pulse_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wdt_ctrl.sv
// Directed self-checking bench for wdt_ctrl; the register-bank counter value is driven by hand.
module tb_wdt_ctrl;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        inten = 1'b0;
    logic        resen = 1'b0;
    logic        stall = 1'b0;
    logic        dbg_halt = 1'b0;
    logic        test_en = 1'b0;
    logic        int_clr = 1'b0;
    logic [31:0] wdtvalue = 32'd0;
    logic        count_en;
    logic        load_en;
    logic        interrupt;
    logic        cause_rst;
    logic        wdogres;

    int vec = 0;
    int errs = 0;

    wdt_ctrl #(.RST_PULSE_CYCLES(16), .PRESCALE_DIV(4)) dut (
        .pclk(pclk), .presetn(presetn), .inten(inten), .resen(resen), .stall(stall),
        .dbg_halt(dbg_halt), .test_en(test_en), .int_clr(int_clr), .wdtvalue(wdtvalue),
        .count_en(count_en), .load_en(load_en), .interrupt(interrupt),
        .cause_rst(cause_rst), .wdogres(wdogres)
    );

    always #5 pclk = ~pclk;

    // Advance to 1 time unit after the next rising edge.
    task automatic nxt;
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset;
        presetn = 1'b0; inten = 1'b1; int_clr = 1'b1; resen = 1'b1; wdtvalue = 32'd0;
        nxt();
        #1;
        vec++; if (count_en !== 1'b0) begin errs++; $display("FAIL rst_count_en: got %b want 0", count_en); end
        vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL rst_load_en: got %b want 0", load_en); end
        vec++; if (interrupt !== 1'b0) begin errs++; $display("FAIL rst_interrupt: got %b want 0", interrupt); end
        vec++; if (wdogres !== 1'b0) begin errs++; $display("FAIL rst_wdogres: got %b want 0", wdogres); end
        vec++; if (cause_rst !== 1'b0) begin errs++; $display("FAIL rst_cause_rst: got %b want 0", cause_rst); end
        presetn = 1'b1; inten = 1'b0; int_clr = 1'b0; resen = 1'b0;
        #1;
        vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL idle_load_en: got %b want 0", load_en); end
        vec++; if (count_en !== 1'b0) begin errs++; $display("FAIL idle_count_en: got %b want 0", count_en); end
        nxt();
    endtask

    task automatic test_enable_count;
        inten = 1'b1; wdtvalue = 32'd3;
        #1;
        vec++; if (load_en !== 1'b1) begin errs++; $display("FAIL en_load: got %b want 1", load_en); end
        vec++; if (count_en !== 1'b0) begin errs++; $display("FAIL en_count_idle: got %b want 0", count_en); end
        nxt();
        for (int v = 3; v >= 1; v--) begin
            wdtvalue = 32'(v);
            #1;
            vec++; if (count_en !== 1'b1) begin errs++; $display("FAIL run_count v=%0d: got %b want 1", v, count_en); end
            vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL run_load v=%0d: got %b want 0", v, load_en); end
            nxt();
        end
        wdtvalue = 32'd0;
        #1;
        vec++; if (load_en !== 1'b1) begin errs++; $display("FAIL zero_load: got %b want 1", load_en); end
        vec++; if (interrupt !== 1'b0) begin errs++; $display("FAIL zero_int_early: got %b want 0", interrupt); end
        nxt();
        wdtvalue = 32'd3;
        #1;
        vec++; if (interrupt !== 1'b1) begin errs++; $display("FAIL int_set: got %b want 1", interrupt); end
        vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL int_load: got %b want 0", load_en); end
        vec++; if (count_en !== 1'b1) begin errs++; $display("FAIL int_count: got %b want 1", count_en); end
        nxt();
    endtask

    task automatic test_int_clr_zero;
        resen = 1'b1; int_clr = 1'b1; wdtvalue = 32'd0;
        #1;
        vec++; if (load_en !== 1'b1) begin errs++; $display("FAIL clr_load: got %b want 1", load_en); end
        nxt();
        int_clr = 1'b0; wdtvalue = 32'd3;
        #1;
        vec++; if (interrupt !== 1'b0) begin errs++; $display("FAIL clr_int: got %b want 0", interrupt); end
        vec++; if (cause_rst !== 1'b0) begin errs++; $display("FAIL clr_cause: got %b want 0", cause_rst); end
        vec++; if (wdogres !== 1'b0) begin errs++; $display("FAIL clr_wdogres: got %b want 0", wdogres); end
        vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL clr_load_once: got %b want 0", load_en); end
        vec++; if (count_en !== 1'b1) begin errs++; $display("FAIL clr_run: got %b want 1", count_en); end
        nxt();
        resen = 1'b0;
    endtask

    task automatic test_reset_pulse;
        logic exp;
        resen = 1'b1; wdtvalue = 32'd0;
        #1;
        vec++; if (load_en !== 1'b1) begin errs++; $display("FAIL rp_first_load: got %b want 1", load_en); end
        nxt();
        #1;
        vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL rp_second_load: got %b want 0", load_en); end
        vec++; if (cause_rst !== 1'b0) begin errs++; $display("FAIL rp_cause_early: got %b want 0", cause_rst); end
        nxt();
        for (int k = 0; k < 16; k++) begin
            int_clr = (k == 4);
            #1;
            vec++; if (wdogres !== 1'b1) begin errs++; $display("FAIL rp_wdogres k=%0d: got %b want 1", k, wdogres); end
            exp = (k == 0);
            vec++; if (cause_rst !== exp) begin errs++; $display("FAIL rp_cause k=%0d: got %b want %b", k, cause_rst, exp); end
            exp = (k == 15);
            vec++; if (load_en !== exp) begin errs++; $display("FAIL rp_load k=%0d: got %b want %b", k, load_en, exp); end
            vec++; if (count_en !== 1'b0) begin errs++; $display("FAIL rp_count k=%0d: got %b want 0", k, count_en); end
            vec++; if (interrupt !== 1'b1) begin errs++; $display("FAIL rp_int k=%0d: got %b want 1", k, interrupt); end
            nxt();
        end
        int_clr = 1'b0; wdtvalue = 32'd3;
        #1;
        vec++; if (wdogres !== 1'b0) begin errs++; $display("FAIL rp_end_wdogres: got %b want 0", wdogres); end
        vec++; if (interrupt !== 1'b0) begin errs++; $display("FAIL rp_end_int: got %b want 0", interrupt); end
        vec++; if (cause_rst !== 1'b0) begin errs++; $display("FAIL rp_end_cause: got %b want 0", cause_rst); end
        vec++; if (count_en !== 1'b1) begin errs++; $display("FAIL rp_end_run: got %b want 1", count_en); end
        nxt();
        resen = 1'b0;
    endtask

    task automatic test_stall;
        stall = 1'b1; dbg_halt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wdtvalue = (k == 5) ? 32'd0 : 32'd7;
            #1;
            vec++; if (count_en !== 1'b0) begin errs++; $display("FAIL stall_count k=%0d: got %b want 0", k, count_en); end
            vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL stall_load k=%0d: got %b want 0", k, load_en); end
            nxt();
        end
        dbg_halt = 1'b0; wdtvalue = 32'd7;
        #1;
        vec++; if (count_en !== 1'b1) begin errs++; $display("FAIL stall_resume: got %b want 1", count_en); end
        vec++; if (interrupt !== 1'b0) begin errs++; $display("FAIL stall_no_int: got %b want 0", interrupt); end
        nxt();
        stall = 1'b0; dbg_halt = 1'b1;
        #1;
        vec++; if (count_en !== 1'b1) begin errs++; $display("FAIL halt_only: got %b want 1", count_en); end
        nxt();
        dbg_halt = 1'b0;
    endtask

    task automatic test_test_en;
        logic exp;
        test_en = 1'b1; resen = 1'b1; wdtvalue = 32'd0;
        #1;
        vec++; if (load_en !== 1'b1) begin errs++; $display("FAIL te_load: got %b want 1", load_en); end
        nxt();
        nxt();
        for (int k = 0; k < 16; k++) begin
            #1;
            vec++; if (wdogres !== 1'b0) begin errs++; $display("FAIL te_wdogres k=%0d: got %b want 0", k, wdogres); end
            exp = (k == 0);
            vec++; if (cause_rst !== exp) begin errs++; $display("FAIL te_cause k=%0d: got %b want %b", k, cause_rst, exp); end
            exp = (k == 15);
            vec++; if (load_en !== exp) begin errs++; $display("FAIL te_load k=%0d: got %b want %b", k, load_en, exp); end
            nxt();
        end
        wdtvalue = 32'd3;
        #1;
        vec++; if (count_en !== 1'b1) begin errs++; $display("FAIL te_run: got %b want 1", count_en); end
        vec++; if (wdogres !== 1'b0) begin errs++; $display("FAIL te_end_wdogres: got %b want 0", wdogres); end
        nxt();
        test_en = 1'b0; resen = 1'b0;
    endtask

    task automatic test_inten_drop;
        wdtvalue = 32'd0;
        nxt();
        inten = 1'b0; wdtvalue = 32'd3;
        #1;
        vec++; if (interrupt !== 1'b1) begin errs++; $display("FAIL drop_int_pend: got %b want 1", interrupt); end
        vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL drop_load: got %b want 0", load_en); end
        nxt();
        #1;
        vec++; if (interrupt !== 1'b0) begin errs++; $display("FAIL drop_int_clr: got %b want 0", interrupt); end
        vec++; if (count_en !== 1'b0) begin errs++; $display("FAIL drop_idle_count: got %b want 0", count_en); end
        inten = 1'b1;
        nxt();
        resen = 1'b1; wdtvalue = 32'd0;
        nxt();
        nxt();
        for (int k = 0; k < 16; k++) begin
            inten = (k < 3);
            #1;
            vec++; if (wdogres !== 1'b1) begin errs++; $display("FAIL drop_pulse k=%0d: got %b want 1", k, wdogres); end
            vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL drop_pulse_load k=%0d: got %b want 0", k, load_en); end
            nxt();
        end
        #1;
        vec++; if (wdogres !== 1'b0) begin errs++; $display("FAIL drop_end_wdogres: got %b want 0", wdogres); end
        vec++; if (interrupt !== 1'b0) begin errs++; $display("FAIL drop_end_int: got %b want 0", interrupt); end
        vec++; if (count_en !== 1'b0) begin errs++; $display("FAIL drop_end_idle: got %b want 0", count_en); end
        nxt();
        resen = 1'b0;
    endtask

    task automatic test_reset_mid_pulse;
        inten = 1'b1; wdtvalue = 32'd3;
        nxt();
        resen = 1'b1; wdtvalue = 32'd0;
        nxt();
        nxt();
        for (int k = 0; k < 5; k++) begin
            #1;
            vec++; if (wdogres !== 1'b1) begin errs++; $display("FAIL mid_pulse k=%0d: got %b want 1", k, wdogres); end
            nxt();
        end
        presetn = 1'b0;
        #1;
        vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL mid_rst_load: got %b want 0", load_en); end
        nxt();
        #1;
        vec++; if (wdogres !== 1'b0) begin errs++; $display("FAIL mid_rst_wdogres: got %b want 0", wdogres); end
        vec++; if (interrupt !== 1'b0) begin errs++; $display("FAIL mid_rst_int: got %b want 0", interrupt); end
        vec++; if (cause_rst !== 1'b0) begin errs++; $display("FAIL mid_rst_cause: got %b want 0", cause_rst); end
        presetn = 1'b1; inten = 1'b0; resen = 1'b0;
        #1;
        vec++; if (count_en !== 1'b0) begin errs++; $display("FAIL mid_rst_idle: got %b want 0", count_en); end
        nxt();
    endtask

    task automatic test_prescale;
        logic exp;
        inten = 1'b1; wdtvalue = 32'd9;
        #1;
        vec++; if (load_en !== 1'b1) begin errs++; $display("FAIL pre_load: got %b want 1", load_en); end
        nxt();
        for (int k = 0; k < 8; k++) begin
            #1;
            exp = ((k % 4) == 3);
            vec++; if (count_en !== exp) begin errs++; $display("FAIL pre_count k=%0d: got %b want %b", k, count_en, exp); end
            nxt();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
`ifdef WDT_PRESCALE_EN
        test_prescale();
`else
        test_enable_count();
        test_int_clr_zero();
        test_reset_pulse();
        test_stall();
        test_test_en();
        test_inten_drop();
        test_reset_mid_pulse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
